// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V core and its fetch front end.
//   EOF_INSTR     : sentinel word that ends the program image
//   opcode_e      : base opcodes decoded by the core
//   fetch_state_e : fetch unit FSM encoding
package riscv_pkg;

  localparam logic [31:0] EOF_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [6:0] {
    OPC_R      = 7'b0110011,
    OPC_LOAD   = 7'b0000011,
    OPC_IMM    = 7'b0010011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_JAL    = 7'b1101111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// Fetch unit bus bundle: instruction RAM port, decode handshake, redirect
// input and status outputs.
//   master : the fetch unit
//   slave  : RAM / consumer / control side
interface riscv_fetch_unit_if;
  logic [31:0] imem_index;
  logic        imem_rd;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        fetch_oob;
  logic [31:0] fetch_count;

  modport master (
    output imem_index, imem_rd, instr, instr_pc, instr_valid, halted,
           fetch_oob, fetch_count,
    input  imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_index, imem_rd, instr, instr_pc, instr_valid, halted,
           fetch_oob, fetch_count,
    output imem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/riscv_fetch_unit_fetch_fifo.sv
// fetch_fifo: DEPTH x WIDTH synchronous FIFO holding {instr, pc} pairs.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write data_i at tail (ignored when flush_i)
//   pop_i      : drop head (ignored when empty)
//   flush_i    : empty the FIFO, priority over push
//   head_o     : head entry
//   count_o    : occupancy
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Storage is reset too so the head reads as zero out of reset.
  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (do_pop) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: instruction fetch front end of the multicycle core.
// Drives a 1-cycle-latency instruction RAM, buffers prefetched words and
// hands them to decode over valid/ready. Stops at the EOF word or when the
// fetch PC leaves the RAM; a redirect flushes and restarts fetching.
//   CLOCK_50 : clock
//   rstn     : asynchronous active-low reset
//   fif      : imem port, instr handshake, redirect, halted/fetch_oob/fetch_count
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter int          IMEM_DEPTH = 35,
  parameter int          BUF_DEPTH  = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                CLOCK_50,
  input  logic                rstn,
  riscv_fetch_unit_if.master  fif
);
  localparam int OCC_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  issued_pc_q;
  logic [31:0]  fetch_count_q;
  logic         inflight_q, inflight_d;
  logic         oob_q, oob_d;

  logic [OCC_W-1:0] occ;
  logic [63:0]      head;
  logic             head_valid;
  logic             redir, out_of_range, issue, push, eof_push, pop;

  assign redir        = fif.redirect_valid && (state_q != FETCH_IDLE);
  assign out_of_range = (pc_q >> 2) >= 32'(IMEM_DEPTH);
  // Credit counts the word in flight; a same-cycle pop frees nothing.
  assign issue        = (state_q == FETCH_RUN) && !out_of_range &&
                        ((32'(occ) + 32'(inflight_q)) < 32'(BUF_DEPTH));
  assign push         = inflight_q && !redir;
  assign eof_push     = push && (fif.imem_rdata == EOF_INSTR);
  assign head_valid   = (occ != '0);
  assign pop          = head_valid && fif.instr_ready;

  fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(64)) u_fifo (
    .clk     (CLOCK_50),
    .rst_n   (rstn),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redir),
    .data_i  ({fif.imem_rdata, issued_pc_q}),
    .head_o  (head),
    .count_o (occ)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    oob_d      = oob_q;
    // A read issued alongside an EOF response or a redirect is dropped by
    // simply not expecting its response.
    inflight_d = issue && !eof_push && !redir;
    if (issue) pc_d = pc_q + 32'd4;
    case (state_q)
      FETCH_IDLE: state_d = FETCH_RUN;
      FETCH_RUN: begin
        if (eof_push) begin
          state_d = FETCH_HALT;
        end else if (out_of_range) begin
          state_d = FETCH_HALT;
          oob_d   = 1'b1;
        end
      end
      FETCH_HALT: state_d = FETCH_HALT;
      default:    state_d = FETCH_IDLE;
    endcase
    if (redir) begin
      state_d = FETCH_RUN;
      pc_d    = {fif.redirect_pc[31:2], 2'b00};
      oob_d   = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= RESET_PC;
      issued_pc_q   <= '0;
      inflight_q    <= 1'b0;
      oob_q         <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      oob_q      <= oob_d;
      if (issue) issued_pc_q <= pc_q;
      if (push)  fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fif.imem_index  = {2'b00, pc_q[31:2]};
  assign fif.imem_rd     = issue;
  assign fif.instr       = head[63:32];
  assign fif.instr_pc    = head[31:0];
  assign fif.instr_valid = head_valid;
  assign fif.halted      = (state_q == FETCH_HALT);
  assign fif.fetch_oob   = oob_q;
  assign fif.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_riscv_fetch_unit.sv
module tb_riscv_fetch_unit;
  import riscv_pkg::*;

  localparam int IMEM_DEPTH = 35;
  localparam int BUF_DEPTH  = 2;

  logic CLOCK_50;
  logic rstn;
  riscv_fetch_unit_if fif();

  riscv_fetch_unit #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .BUF_DEPTH  (BUF_DEPTH),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rstn     (rstn),
    .fif      (fif)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // Behavioural instruction RAM, one cycle read latency.
  logic [31:0] mem [IMEM_DEPTH];
  always @(posedge CLOCK_50) begin
    if (fif.imem_rd)
      fif.imem_rdata <= (fif.imem_index < 32'(IMEM_DEPTH)) ? mem[fif.imem_index[5:0]] : 32'h0;
  end

  int          n_chk, n_pass, rd_cnt;
  logic [63:0] exp_q[$];
  logic        exp_oob, redir_prev, drain_done, smp_valid;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected delivery stream from a start PC: consecutive words until the
  // EOF word (delivered) or the first index outside the RAM.
  function automatic void walk(input logic [31:0] start);
    logic [31:0] p;
    p = {start[31:2], 2'b00};
    exp_q.delete();
    exp_oob = 1'b0;
    for (int n = 0; n < 64; n++) begin
      if ((p >> 2) >= 32'(IMEM_DEPTH)) begin
        exp_oob = 1'b1;
        break;
      end
      exp_q.push_back({mem[p[7:2]], p});
      if (mem[p[7:2]] == EOF_INSTR) break;
      p = p + 32'd4;
    end
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == EOF_INSTR) w = 32'h0000_0013;
    return w;
  endfunction

  // One cycle: drive inputs just after the falling edge, sample, score.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
    logic [63:0] e;
    fif.instr_ready    = rdy;
    fif.redirect_valid = redir;
    fif.redirect_pc    = tgt;
    #1;
    smp_valid = fif.instr_valid;
    if (redir_prev) begin
      chk("redirect_flush_valid", 64'(fif.instr_valid), 64'd0);
      chk("redirect_halted_clr", 64'(fif.halted), 64'd0);
      chk("redirect_oob_clr", 64'(fif.fetch_oob), 64'd0);
    end
    if (fif.imem_rd) begin
      rd_cnt++;
      chk("imem_index_in_range", 64'(fif.imem_index < 32'(IMEM_DEPTH)), 64'd1);
    end
    if (fif.halted) chk("no_read_when_halted", 64'(fif.imem_rd), 64'd0);
    if (fif.instr_valid && rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 64'(fif.instr_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("instr", 64'(fif.instr), 64'(e[63:32]));
        chk("instr_pc", 64'(fif.instr_pc), 64'(e[31:0]));
      end
    end
    if (fif.halted && !fif.instr_valid && !drain_done) begin
      chk("stream_complete", 64'(exp_q.size()), 64'd0);
      chk("halt_cause_oob", 64'(fif.fetch_oob), 64'(exp_oob));
      drain_done = 1'b1;
    end
    if (redir) begin
      walk(tgt);
      drain_done = 1'b0;
    end
    redir_prev = redir;
    @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    rstn               = 1'b0;
    fif.instr_ready    = 1'b0;
    fif.redirect_valid = 1'b0;
    fif.redirect_pc    = 32'h0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    rstn       = 1'b1;
    walk(32'h0);
    redir_prev = 1'b0;
    drain_done = 1'b0;
  endtask

  initial begin
    int first;
    n_chk = 0; n_pass = 0; rd_cnt = 0;
    redir_prev = 1'b0; drain_done = 1'b0; smp_valid = 1'b0;
    rstn = 1'b0;
    fif.imem_rdata = 32'h0;

    // Basic program: three instructions then EOF.
    for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = rnd_word();
    mem[0] = 32'h0000_0013; mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_8133; mem[3] = EOF_INSTR;
    #1;
    chk("reset_valid", 64'(fif.instr_valid), 64'd0);
    chk("reset_imem_rd", 64'(fif.imem_rd), 64'd0);
    chk("reset_count", 64'(fif.fetch_count), 64'd0);
    do_reset();
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b0, 32'h0);
      if (smp_valid && first == 0) first = k;
    end
    chk("first_valid_latency", 64'(first - 1), 64'd3);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 32'h0);
    chk("eof_halted", 64'(fif.halted), 64'd1);
    chk("eof_fetch_count", 64'(fif.fetch_count), 64'd4);
    rd_cnt = 0;
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 32'h0);
    chk("no_reads_after_eof", 64'(rd_cnt), 64'd0);

    // Stalled consumer: only BUF_DEPTH reads, then in-order drain.
    do_reset();
    rd_cnt = 0;
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0);
    chk("reads_while_stalled", 64'(rd_cnt), 64'(BUF_DEPTH));
    #1;
    chk("stall_head_valid", 64'(fif.instr_valid), 64'd1);
    chk("stall_head_pc", 64'(fif.instr_pc), 64'(exp_q[0][31:0]));
    for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 32'h0);
    chk("stall_fetch_count", 64'(fif.fetch_count), 64'd4);

    // Redirect with a word in flight, then redirects out of halt.
    for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = rnd_word();
    mem[8] = EOF_INSTR; mem[18] = EOF_INSTR;
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0011);
    fif.instr_ready = 1'b0; fif.redirect_valid = 1'b0;
    #1;
    chk("redirect_issue_rd", 64'(fif.imem_rd), 64'd1);
    chk("redirect_issue_index", 64'(fif.imem_index), 64'd4);
    step(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 32'h0);
    chk("redirect_fetch_count", 64'(fif.fetch_count), 64'd7);
    chk("redirect_halted", 64'(fif.halted), 64'd1);
    step(1'b1, 1'b1, 32'h0000_0040);
    for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 32'h0);
    chk("resume_fetch_count", 64'(fif.fetch_count), 64'd10);
    chk("resume_halted", 64'(fif.halted), 64'd1);
    step(1'b1, 1'b1, 32'h0000_0088);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 32'h0);
    chk("oob_halted", 64'(fif.halted), 64'd1);
    chk("oob_flag", 64'(fif.fetch_oob), 64'd1);
    chk("oob_fetch_count", 64'(fif.fetch_count), 64'd11);

    // Asynchronous reset while a read is in flight.
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(fif.instr_valid), 64'd0);
    chk("async_rst_instr", 64'(fif.instr), 64'd0);
    chk("async_rst_pc", 64'(fif.instr_pc), 64'd0);
    chk("async_rst_rd", 64'(fif.imem_rd), 64'd0);
    chk("async_rst_index", 64'(fif.imem_index), 64'd0);
    chk("async_rst_halted", 64'(fif.halted), 64'd0);
    chk("async_rst_oob", 64'(fif.fetch_oob), 64'd0);
    chk("async_rst_count", 64'(fif.fetch_count), 64'd0);
    do_reset();
    for (int k = 0; k < 25; k++) step(1'b1, 1'b0, 32'h0);
    chk("restart_fetch_count", 64'(fif.fetch_count), 64'd9);

    // Random ready / redirect traffic over a random program.
    for (int i = 0; i < IMEM_DEPTH; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? EOF_INSTR : rnd_word();
    do_reset();
    for (int k = 1; k <= 2000; k++) begin
      logic rdy, rd;
      logic [31:0] tgt;
      rdy = ($urandom_range(0, 3) != 0);
      rd  = (k >= 2) && (($urandom_range(0, 19) == 0) || drain_done);
      tgt = ($urandom_range(0, 37) << 2) | $urandom_range(0, 3);
      step(rdy, rd, tgt);
    end
    for (int k = 0; k < 80; k++) step(1'b1, 1'b0, 32'h0);
    chk("random_final_halted", 64'(fif.halted), 64'd1);
    chk("random_final_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
